// File: rtl/round_robin_bus_arbiter_if.sv
// Bus-ownership handshake between the round-robin arbiter (master) and the
// requesting sources plus the downstream mux select (slave).
interface round_robin_bus_arbiter_if #(
  parameter int NumberOfRequesters = 4
);
  logic [NumberOfRequesters-1:0] Request;
  logic [NumberOfRequesters-1:0] Grant;
  logic [NumberOfRequesters-1:0] Select;
  logic                          Valid;
  logic                          Timeout;

  modport master (
    input  Request,
    output Grant,
    output Select,
    output Valid,
    output Timeout
  );

  modport slave (
    output Request,
    input  Grant,
    input  Select,
    input  Valid,
    input  Timeout
  );
endinterface

// File: rtl/round_robin_bus_arbiter.sv
// Round-robin owner selection for a shared bus with a bounded hold time and a
// single dead turnaround cycle between consecutive owners.
module round_robin_bus_arbiter #(
  parameter int NumberOfRequesters = 4,
  parameter int MaxHoldCycles      = 15
) (
  input  logic                      i_Clock,
  input  logic                      i_Resetn,
  round_robin_bus_arbiter_if.master io_Bus
);

  localparam int OwnerWidth   = $clog2(NumberOfRequesters);
  localparam int ScanWidth    = OwnerWidth + 1;
  localparam int CounterWidth = (MaxHoldCycles > 1) ? $clog2(MaxHoldCycles) : 1;

  localparam logic [CounterWidth-1:0] LastCount      = CounterWidth'(MaxHoldCycles - 1);
  localparam logic [ScanWidth-1:0]    RequesterCount = ScanWidth'(NumberOfRequesters);
  localparam logic [OwnerWidth-1:0]   LastOwner      = OwnerWidth'(NumberOfRequesters - 1);

  typedef enum logic [1:0] {
    StateIdle    = 2'd0,
    StateOwned   = 2'd1,
    StateRelease = 2'd2
  } ArbState;

  ArbState                       r_state;
  ArbState                       w_nextState;
  logic [OwnerWidth-1:0]         r_owner;
  logic [OwnerWidth-1:0]         w_nextOwner;
  logic [OwnerWidth-1:0]         r_pointer;
  logic [OwnerWidth-1:0]         w_nextPointer;
  logic [CounterWidth-1:0]       r_counter;
  logic [CounterWidth-1:0]       w_nextCounter;
  logic [NumberOfRequesters-1:0] r_grant;
  logic [NumberOfRequesters-1:0] w_nextGrant;
  logic                          r_timeout;
  logic                          w_nextTimeout;

  logic                          w_found;
  logic [OwnerWidth-1:0]         w_winner;
  logic [ScanWidth-1:0]          w_scanIndex;
  logic [OwnerWidth-1:0]         w_ownerPlusOne;
  logic                          w_ownerRequest;

  // Scan upward from the pointer with wrap; the first requester found wins.
  always_comb begin
    w_found     = 1'b0;
    w_winner    = '0;
    w_scanIndex = '0;
    for (int i = 0; i < NumberOfRequesters; i++) begin
      w_scanIndex = {1'b0, r_pointer} + ScanWidth'(i);
      if (w_scanIndex >= RequesterCount) begin
        w_scanIndex = w_scanIndex - RequesterCount;
      end
      if (!w_found && io_Bus.Request[w_scanIndex[OwnerWidth-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_scanIndex[OwnerWidth-1:0];
      end
    end
  end

  always_comb begin
    w_ownerPlusOne = (r_owner == LastOwner) ? '0 : r_owner + OwnerWidth'(1);
    w_ownerRequest = io_Bus.Request[r_owner];
  end

  always_ff @(posedge i_Clock or negedge i_Resetn) begin
    if (!i_Resetn) begin
      r_state   <= StateIdle;
      r_owner   <= '0;
      r_pointer <= '0;
      r_counter <= '0;
      r_grant   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_owner   <= w_nextOwner;
      r_pointer <= w_nextPointer;
      r_counter <= w_nextCounter;
      r_grant   <= w_nextGrant;
      r_timeout <= w_nextTimeout;
    end
  end

  // Owner index is only overwritten on a new grant, so Select holds while idle.
  always_comb begin
    w_nextState   = r_state;
    w_nextOwner   = r_owner;
    w_nextPointer = r_pointer;
    w_nextCounter = r_counter;
    w_nextGrant   = r_grant;
    w_nextTimeout = 1'b0;
    case (r_state)
      StateIdle, StateRelease: begin
        if (w_found) begin
          w_nextState   = StateOwned;
          w_nextOwner   = w_winner;
          w_nextCounter = '0;
          w_nextGrant   = NumberOfRequesters'(1) << w_winner;
        end else begin
          w_nextState = StateIdle;
          w_nextGrant = '0;
        end
      end
      StateOwned: begin
        if (!w_ownerRequest || (r_counter == LastCount)) begin
          w_nextState   = StateRelease;
          w_nextGrant   = '0;
          w_nextPointer = w_ownerPlusOne;
          w_nextTimeout = w_ownerRequest;
        end else begin
          w_nextCounter = r_counter + CounterWidth'(1);
        end
      end
      default: begin
        w_nextState = StateIdle;
        w_nextGrant = '0;
      end
    endcase
  end

  always_comb begin
    io_Bus.Grant   = r_grant;
    io_Bus.Select  = NumberOfRequesters'(r_owner);
    io_Bus.Valid   = (r_state == StateOwned);
    io_Bus.Timeout = r_timeout;
  end

  grantOneHot: assert property (@(posedge i_Clock) disable iff (!i_Resetn)
    $onehot0(r_grant));

  grantMatchesOwner: assert property (@(posedge i_Clock) disable iff (!i_Resetn)
    r_grant == ((r_state == StateOwned) ? (NumberOfRequesters'(1) << r_owner)
                                        : {NumberOfRequesters{1'b0}}));

  counterInRange: assert property (@(posedge i_Clock) disable iff (!i_Resetn)
    r_counter <= LastCount);

endmodule

// File: tb/tb_round_robin_bus_arbiter.sv
// Scoreboard bench: stimulus queues the expected outputs of every cycle, a
// negedge monitor pops each entry and compares it with the addressed DUT.
module tb_round_robin_bus_arbiter;

  localparam bit DutA = 1'b0;
  localparam bit DutB = 1'b1;

  logic clock;
  logic resetn;

  round_robin_bus_arbiter_if #(.NumberOfRequesters(4)) busA ();
  round_robin_bus_arbiter_if #(.NumberOfRequesters(4)) busB ();

  round_robin_bus_arbiter #(.NumberOfRequesters(4), .MaxHoldCycles(15)) dutA (
    .i_Clock  (clock),
    .i_Resetn (resetn),
    .io_Bus   (busA)
  );

  round_robin_bus_arbiter #(.NumberOfRequesters(4), .MaxHoldCycles(4)) dutB (
    .i_Clock  (clock),
    .i_Resetn (resetn),
    .io_Bus   (busB)
  );

  typedef struct packed {
    logic       dutSel;
    logic [7:0] phase;
    logic [7:0] cyc;
    logic [3:0] grant;
    logic [3:0] select;
    logic       valid;
    logic       timeout;
  } ExpEntry;

  ExpEntry expQ[$];
  ExpEntry monEntry;
  logic [3:0] actGrant;
  logic [3:0] actSelect;
  logic       actValid;
  logic       actTimeout;

  int checks   = 0;
  int failures = 0;
  int phaseNum = 0;
  int cycleNum = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives the inputs sampled at the next edge and queues what must be seen now.
  task automatic applyStimulus(input logic dutSel, input logic resetnVal,
                               input logic [3:0] req, input logic [3:0] eGrant,
                               input logic [3:0] eSelect, input logic eValid,
                               input logic eTimeout);
    ExpEntry e;
    @(posedge clock);
    #1;
    resetn = resetnVal;
    if (dutSel) busB.Request = req;
    else        busA.Request = req;
    e.dutSel  = dutSel;
    e.phase   = 8'(phaseNum);
    e.cyc     = 8'(cycleNum);
    e.grant   = eGrant;
    e.select  = eSelect;
    e.valid   = eValid;
    e.timeout = eTimeout;
    expQ.push_back(e);
    cycleNum++;
  endtask

  task automatic startPhase(input int p);
    phaseNum = p;
    cycleNum = 0;
  endtask

  task automatic checkOutput(input ExpEntry e, input logic [3:0] g, input logic [3:0] s,
                             input logic v, input logic t);
    checks++;
    if ({g, s, v, t} !== {e.grant, e.select, e.valid, e.timeout}) begin
      failures++;
      $display("[TB] FAIL outputs p%0d.c%0d dut%0d: got grant=%b select=%0d valid=%b timeout=%b, want grant=%b select=%0d valid=%b timeout=%b",
               e.phase, e.cyc, e.dutSel, g, s, v, t, e.grant, e.select, e.valid, e.timeout);
    end
  endtask

  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      monEntry = expQ.pop_front();
      if (monEntry.dutSel) begin
        actGrant   = busB.Grant;
        actSelect  = busB.Select;
        actValid   = busB.Valid;
        actTimeout = busB.Timeout;
      end else begin
        actGrant   = busA.Grant;
        actSelect  = busA.Select;
        actValid   = busA.Valid;
        actTimeout = busA.Timeout;
      end
      checkOutput(monEntry, actGrant, actSelect, actValid, actTimeout);
    end
  end

  initial begin
    resetn       = 1'b0;
    busA.Request = 4'b0000;
    busB.Request = 4'b0000;

    // reset state on both instances
    startPhase(1);
    applyStimulus(DutA, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);
    applyStimulus(DutB, 1'b0, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);

    // single request from source 2, dropped after two owned cycles
    startPhase(2);
    applyStimulus(DutA, 1'b1, 4'b0100, 4'b0000, 4'd0, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0100, 4'b0100, 4'd2, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0100, 4'd2, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0000, 4'd2, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0000, 4'd2, 1'b0, 1'b0);

    // minimum ownership: source 3 requests for one sampling edge only
    startPhase(3);
    applyStimulus(DutA, 1'b1, 4'b1000, 4'b0000, 4'd2, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b1000, 4'd3, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0000, 4'd3, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0000, 4'd3, 1'b0, 1'b0);

    // wrap-around: source 2 releases (pointer 3), then sources 0 and 1 contend
    startPhase(4);
    applyStimulus(DutA, 1'b1, 4'b0100, 4'b0000, 4'd3, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0100, 4'd2, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0011, 4'b0000, 4'd2, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0011, 4'b0001, 4'd0, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0010, 4'b0001, 4'd0, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0010, 4'b0000, 4'd0, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0010, 4'd1, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0000, 4'd1, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0000, 4'd1, 1'b0, 1'b0);

    // hold limit of 15 with a lone requester, re-granted after the dead cycle
    startPhase(5);
    applyStimulus(DutA, 1'b1, 4'b0010, 4'b0000, 4'd1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      applyStimulus(DutA, 1'b1, 4'b0010, 4'b0010, 4'd1, 1'b1, 1'b0);
    end
    applyStimulus(DutA, 1'b1, 4'b0010, 4'b0000, 4'd1, 1'b0, 1'b1);
    applyStimulus(DutA, 1'b1, 4'b0010, 4'b0010, 4'd1, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0010, 4'b0010, 4'd1, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0010, 4'd1, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0000, 4'd1, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0000, 4'd1, 1'b0, 1'b0);

    // asynchronous reset while source 1 owns the bus
    startPhase(6);
    applyStimulus(DutA, 1'b1, 4'b0010, 4'b0000, 4'd1, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0010, 4'b0010, 4'd1, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b0, 4'b0011, 4'b0000, 4'd0, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0011, 4'b0000, 4'd0, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0001, 4'd0, 1'b1, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);
    applyStimulus(DutA, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);

    // full contention with a hold limit of 4: order 0,1,2,3,0, period 5
    startPhase(7);
    applyStimulus(DutB, 1'b1, 4'b1111, 4'b0000, 4'd0, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int h = 0; h < 4; h++) begin
        applyStimulus(DutB, 1'b1, 4'b1111, 4'(1) << (r % 4), 4'(r % 4), 1'b1, 1'b0);
      end
      applyStimulus(DutB, 1'b1, (r == 4) ? 4'b0000 : 4'b1111, 4'b0000, 4'(r % 4), 1'b0, 1'b1);
    end
    applyStimulus(DutB, 1'b1, 4'b0000, 4'b0000, 4'd0, 1'b0, 1'b0);

    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
